// File: rtl/param_seq_divider.sv
// param_seq_divider
//   Multi-cycle restoring divider, one quotient bit per clock, MSB first.
//   Operands are reduced to unsigned magnitudes when the operation is accepted.
//   The signs are reapplied in a final fix-up cycle. The quotient truncates
//   toward zero and the remainder takes the sign of the dividend.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request; accepted only while busy=0
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b         dividend / divisor (sampled with start)
//   busy         operation in progress
//   done         one-cycle pulse when q/r/div_by_zero are updated
//   q, r         registered quotient / remainder, held until the next done
//   div_by_zero  set with done when the sampled divisor was zero
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; a zero divisor is answered here in one edge
// S_CALC | WIDTH shift/subtract iterations, counter counts WIDTH down to 1
// S_FIX  | apply result signs, pulse done, drop busy
module param_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // The magnitude of the most-negative value is 2^(WIDTH-1), which still
  // fits in WIDTH unsigned bits, so no special case is needed.
  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // The shifted partial remainder needs WIDTH+1 bits for the compare. After a
  // subtraction the difference is below the divisor, so WIDTH bits hold it.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_diff  = rem_shift[WIDTH-1:0] - dvs_q;
  assign rem_d     = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
  assign dvd_d     = {dvd_q[WIDTH-2:0], rem_ge};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (b == '0) begin
              q_q    <= '1;
              r_q    <= a;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              dvd_q      <= a_mag;
              dvs_q      <= b_mag;
              rem_q      <= '0;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              cnt_q      <= CNT_W'(WIDTH);
              busy_q     <= 1'b1;
              state_q    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          q_q     <= neg_quot_q ? -dvd_q : dvd_q;
          r_q     <= neg_rem_q ? -rem_q : rem_q;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule
